// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared core definitions used by the instruction-memory loader, fetch and
// memory blocks.
//   load_state_e     : loader FSM states (IDLE / LOAD / DONE)
//   DEFAULT_BASEADDR : default byte address of the first loaded word
//   WORD_SHIFT       : log2 of the byte stride between consecutive words
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  localparam logic [31:0] DEFAULT_BASEADDR = 32'h0100_0000;

  // Words are 4 bytes apart in the byte-addressed memory map.
  localparam int WORD_SHIFT = 2;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's stream input and its memory write port.
//   s_valid_i / s_data_i / s_ready_o : instruction word stream (valid/ready)
//   mem_addr_o / mem_data_o          : memory write address and data
//   mem_write_en_o / mem_read_en_o   : memory strobes
// Modports:
//   master : the loader (drives the memory port, accepts the stream)
//   slave  : the environment (drives the stream, receives memory writes)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  logic              s_valid_i;
  logic [DWIDTH-1:0] s_data_i;
  logic              s_ready_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_write_en_o;
  logic              mem_read_en_o;

  modport master (
    input  s_valid_i,
    input  s_data_i,
    output s_ready_o,
    output mem_addr_o,
    output mem_data_o,
    output mem_write_en_o,
    output mem_read_en_o
  );

  modport slave (
    output s_valid_i,
    output s_data_i,
    input  s_ready_o,
    input  mem_addr_o,
    input  mem_data_o,
    input  mem_write_en_o,
    input  mem_read_en_o
  );

endinterface : imem_loader_if

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Copies len_i words from a valid/ready stream into instruction memory,
// starting at BASEADDR, while holding the core in reset. When the last word
// is written the loader enters DONE and releases core_rst_o.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start_i, len_i  : load request and word count (sampled in IDLE/DONE only)
//   bus             : stream input + memory write port (imem_loader_if.master)
//   busy_o, done_o  : loader in LOAD / DONE
//   core_rst_o      : core held in reset until the load completes
//   checksum_o      : XOR of all words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(DEFAULT_BASEADDR),
  parameter int                LWIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LWIDTH-1:0] len_i,
  imem_loader_if.master     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              core_rst_o,
  output logic [DWIDTH-1:0] checksum_o
);

  load_state_e       state_reg, state_next;
  logic [LWIDTH-1:0] count_reg, count_next;
  logic [LWIDTH-1:0] len_reg, len_next;
  logic [DWIDTH-1:0] checksum_reg, checksum_next;

  logic load_active;   // LOAD state, suppressed while rst is high
  logic start_accept;
  logic handshake;
  logic last_word;

  // Outputs are qualified with rst so nothing leaks out during the reset
  // cycle itself, even if the registered state is still LOAD/DONE.
  assign load_active  = (state_reg == ST_LOAD) && !rst;
  assign start_accept = start_i && (state_reg != ST_LOAD);
  assign handshake    = bus.s_valid_i && load_active;
  // len_reg is never 0 while in LOAD, so len_reg-1 does not underflow there.
  assign last_word    = (count_reg == (len_reg - LWIDTH'(1)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_next = (len_i == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A new start_i here is deliberately ignored.
        if (handshake && last_word) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: word counter, latched length, running checksum
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next    = count_reg;
    len_next      = len_reg;
    checksum_next = checksum_reg;
    if (start_accept) begin
      count_next    = '0;
      len_next      = len_i;
      checksum_next = '0;
    end else if (handshake) begin
      count_next    = count_reg + LWIDTH'(1);
      checksum_next = checksum_reg ^ bus.s_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      len_reg      <= '0;
      checksum_reg <= '0;
    end else begin
      count_reg    <= count_next;
      len_reg      <= len_next;
      checksum_reg <= checksum_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.s_ready_o      = load_active;
    bus.mem_write_en_o = handshake;
    bus.mem_data_o     = bus.s_data_i;
    bus.mem_read_en_o  = 1'b0;
    // Address arithmetic wraps modulo 2^AWIDTH by construction.
    if (rst) begin
      bus.mem_addr_o = BASEADDR;
    end else begin
      bus.mem_addr_o = BASEADDR + (AWIDTH'(count_reg) << WORD_SHIFT);
    end
    busy_o     = load_active;
    done_o     = (state_reg == ST_DONE) && !rst;
    core_rst_o = !((state_reg == ST_DONE) && !rst);
    checksum_o = rst ? '0 : checksum_reg;
  end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Two loaders (default base and a base near the top of the address space)
// share one stimulus stream. A behavioural model (remaining-word count, next
// word index, running XOR) predicts every output each cycle; directed
// scenarios add literal expectations, then randomized loads follow.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE_A = 32'h0100_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;

  logic        busy_a, done_a, core_rst_a;
  logic [31:0] checksum_a;
  logic        busy_b, done_b, core_rst_b;
  logic [31:0] checksum_b;

  imem_loader_if #(.AWIDTH(32), .DWIDTH(32)) bus_a ();
  imem_loader_if #(.AWIDTH(32), .DWIDTH(32)) bus_b ();

  assign bus_a.s_valid_i = s_valid;
  assign bus_a.s_data_i  = s_data;
  assign bus_b.s_valid_i = s_valid;
  assign bus_b.s_data_i  = s_data;

  imem_loader #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE_A), .LWIDTH(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .len_i      (len),
    .bus        (bus_a),
    .busy_o     (busy_a),
    .done_o     (done_a),
    .core_rst_o (core_rst_a),
    .checksum_o (checksum_a)
  );

  imem_loader #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE_B), .LWIDTH(16)) u_dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .len_i      (len),
    .bus        (bus_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .core_rst_o (core_rst_b),
    .checksum_o (checksum_b)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_loading = 1'b0;
  bit          m_finished = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_idx = '0;
  logic [31:0] m_xor = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] log_a_addr[$];
  logic [31:0] log_a_data[$];
  logic [31:0] log_b_addr[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance on a rising edge, from the inputs present in that cycle.
  task automatic model_update();
    if (rst) begin
      m_loading = 1'b0; m_finished = 1'b0; m_rem = 0; m_idx = '0; m_xor = '0;
    end else if (start && !m_loading) begin
      m_idx = '0; m_xor = '0;
      if (len == 16'd0) begin
        m_finished = 1'b1; m_loading = 1'b0;
      end else begin
        m_loading = 1'b1; m_finished = 1'b0; m_rem = int'(len);
      end
    end else if (m_loading && s_valid) begin
      m_xor = m_xor ^ s_data;
      m_idx = m_idx + 32'd1;
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_loading = 1'b0; m_finished = 1'b1;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_ready, exp_we, exp_done;
    exp_ready = m_loading && !rst;
    exp_we    = exp_ready && s_valid;
    exp_done  = m_finished && !rst;
    chk1("s_ready_a", bus_a.s_ready_o, exp_ready);
    chk1("we_a", bus_a.mem_write_en_o, exp_we);
    chk1("re_a", bus_a.mem_read_en_o, 1'b0);
    chk32("addr_a", bus_a.mem_addr_o, rst ? BASE_A : BASE_A + (m_idx << 2));
    chk32("data_a", bus_a.mem_data_o, s_data);
    chk1("busy_a", busy_a, exp_ready);
    chk1("done_a", done_a, exp_done);
    chk1("core_rst_a", core_rst_a, !exp_done);
    chk32("checksum_a", checksum_a, rst ? 32'd0 : m_xor);
    chk1("we_b", bus_b.mem_write_en_o, exp_we);
    chk32("addr_b", bus_b.mem_addr_o, rst ? BASE_B : BASE_B + (m_idx << 2));
    chk1("done_b", done_b, exp_done);
    chk32("checksum_b", checksum_b, rst ? 32'd0 : m_xor);
    if (bus_a.mem_write_en_o === 1'b1) begin
      log_a_addr.push_back(bus_a.mem_addr_o);
      log_a_data.push_back(bus_a.mem_data_o);
      $display("write A addr=%h data=%h", bus_a.mem_addr_o, bus_a.mem_data_o);
    end
    if (bus_b.mem_write_en_o === 1'b1) begin
      log_b_addr.push_back(bus_b.mem_addr_o);
    end
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input bit st, input int ln, input bit v,
                       input logic [31:0] d, input bit r);
    start = st; len = 16'(ln); s_valid = v; s_data = d; rst = r;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_logs();
    log_a_addr.delete(); log_a_data.delete(); log_b_addr.delete();
  endtask

  logic [31:0] words3[3];
  bit          vpat[7];

  initial begin
    words3[0] = 32'h0000_0013;
    words3[1] = 32'h0050_0093;
    words3[2] = 32'h00A0_0113;

    // Reset
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk1("rst_done", done_a, 1'b0);
    chk1("rst_core_rst", core_rst_a, 1'b1);
    chk32("rst_addr", bus_a.mem_addr_o, 32'h0100_0000);
    cycle(0, 0, 0, 0, 0);
    $display("txn reset done");

    // Three back-to-back words
    clear_logs();
    cycle(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, words3[i], 0);
    chk32("t1_nwrites", 32'(log_a_addr.size()), 32'd3);
    if (log_a_addr.size() == 3) begin
      chk32("t1_addr0", log_a_addr[0], 32'h0100_0000);
      chk32("t1_addr1", log_a_addr[1], 32'h0100_0004);
      chk32("t1_addr2", log_a_addr[2], 32'h0100_0008);
    end
    chk32("t1_checksum", checksum_a, 32'h00F0_0193);
    chk32("t1_model_xor", m_xor, 32'h00F0_0193);
    chk1("t1_done", done_a, 1'b1);
    chk1("t1_core_rst", core_rst_a, 1'b0);
    chk32("wrap_nwrites", 32'(log_b_addr.size()), 32'd3);
    if (log_b_addr.size() == 3) begin
      chk32("wrap_addr0", log_b_addr[0], 32'hFFFF_FFF8);
      chk32("wrap_addr1", log_b_addr[1], 32'hFFFF_FFFC);
      chk32("wrap_addr2", log_b_addr[2], 32'h0000_0000);
    end
    $display("txn len3 checksum=%h", checksum_a);

    // Stalls
    clear_logs();
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    cycle(1, 4, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, vpat[i], $urandom, 0);
    chk32("t2_nwrites", 32'(log_a_addr.size()), 32'd4);
    for (int i = 0; i < log_a_addr.size(); i++)
      chk32("t2_addr", log_a_addr[i], 32'h0100_0000 + 32'(i * 4));
    $display("txn len4 stalls writes=%0d", log_a_addr.size());

    // Zero length
    clear_logs();
    cycle(1, 0, 1, 32'hDEAD_BEEF, 0);
    chk1("t3_done", done_a, 1'b1);
    chk32("t3_checksum", checksum_a, 32'd0);
    chk1("t3_core_rst", core_rst_a, 1'b0);
    cycle(0, 0, 1, 32'h1234_5678, 0);
    chk32("t3_nwrites", 32'(log_a_addr.size()), 32'd0);
    $display("txn len0");

    // Reset mid-load
    clear_logs();
    cycle(1, 5, 0, 0, 0);
    cycle(0, 0, 1, 32'h1111_1111, 0);
    cycle(0, 0, 1, 32'h2222_2222, 0);
    cycle(0, 0, 1, 32'h3333_3333, 1);
    chk1("t4_busy", busy_a, 1'b0);
    chk1("t4_core_rst", core_rst_a, 1'b1);
    chk32("t4_addr", bus_a.mem_addr_o, 32'h0100_0000);
    cycle(0, 0, 0, 0, 0);
    clear_logs();
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 1, 32'hAAAA_0001, 0);
    cycle(0, 0, 1, 32'hAAAA_0002, 0);
    chk32("t4_nwrites", 32'(log_a_addr.size()), 32'd2);
    if (log_a_addr.size() == 2) begin
      chk32("t4_addr0", log_a_addr[0], 32'h0100_0000);
      chk32("t4_addr1", log_a_addr[1], 32'h0100_0004);
    end
    $display("txn reset-midload");

    // Start ignored mid-load, then restart from DONE
    clear_logs();
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0A0A, 0);
    cycle(1, 7, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0B0B, 0);
    cycle(0, 0, 1, 32'h0000_0C0C, 0);
    chk32("t5_nwrites", 32'(log_a_addr.size()), 32'd3);
    chk1("t5_done", done_a, 1'b1);
    chk32("t5_checksum", checksum_a, 32'h0000_0D0D);
    cycle(1, 2, 0, 0, 0);
    chk32("t5_restart_checksum", checksum_a, 32'd0);
    chk32("t5_restart_addr", bus_a.mem_addr_o, 32'h0100_0000);
    chk1("t5_restart_busy", busy_a, 1'b1);
    cycle(0, 0, 1, 32'h5, 0);
    cycle(0, 0, 1, 32'h6, 0);
    $display("txn start-ignored");

    // Randomized loads
    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(0, 12);
      cycle(1, n, $urandom_range(0, 1), $urandom, 0);
      for (int c = 0; c < n * 4 + 10 && m_loading; c++) begin
        if ($urandom_range(0, 59) == 0)
          cycle(0, 0, 1, $urandom, 1);
        else
          cycle($urandom_range(0, 7) == 0, $urandom_range(0, 20),
                $urandom_range(0, 2) != 0, $urandom, 0);
      end
      cycle(0, 0, $urandom_range(0, 1), $urandom, 0);
      $display("txn random %0d len=%0d done=%b checksum=%h", t, n, done_a, checksum_a);
    end

    cycle(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter AWIDTH, default 32, memory address width.
REQ-002 Parameter DWIDTH, default 32, memory data/word width.
REQ-003 Parameter BASEADDR, default 32'h0100_0000, address of first loaded word.
REQ-004 Parameter LWIDTH, default 16, width of word-count length field.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start_i  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-008 len_i  input  LWIDTH  number of words to load; latched when start_i is accepted.
REQ-009 s_valid_i  input  1  stream word valid.
REQ-010 s_data_i  input  DWIDTH  stream word (instruction).
REQ-011 s_ready_o  output  1  loader can accept a stream word this cycle.
REQ-012 mem_addr_o  output  AWIDTH  memory write address.
REQ-013 mem_data_o  output  DWIDTH  memory write data.
REQ-014 mem_write_en_o  output  1  memory write strobe.
REQ-015 mem_read_en_o  output  1  memory read enable; constant 0.
REQ-016 busy_o  output  1  load in progress.
REQ-017 done_o  output  1  load complete.
REQ-018 core_rst_o  output  1  holds fetch/core in reset until load completes.
REQ-019 checksum_o  output  DWIDTH  XOR of all words written in current/last load.

Function
REQ-020 FSM states IDLE, LOAD, DONE; IDLE->LOAD on start_i with len_i!=0; IDLE->DONE on start_i with len_i==0.
REQ-021 LOAD->DONE on the handshake of word index len-1; DONE->LOAD/DONE on new start_i per REQ-020 rules.
REQ-022 start_i while in LOAD is ignored; latched length and progress unaffected.
REQ-023 Accepting start_i clears word counter and checksum_o to 0 in the same edge.
REQ-024 s_ready_o = 1 exactly when state is LOAD; 0 in IDLE and DONE.
REQ-025 Handshake = s_valid_i && s_ready_o; mem_write_en_o equals handshake combinationally (zero-latency pass-through).
REQ-026 mem_data_o = s_data_i combinationally; mem_addr_o = BASEADDR + 4*count, truncated modulo 2^AWIDTH.
REQ-027 Counter (LWIDTH bits) increments by 1 per handshake; no increment without handshake; stalls (s_valid_i=0) hold all state.
REQ-028 checksum_o updates to checksum_o XOR s_data_i on each handshake, visible the following cycle.
REQ-029 busy_o = (state==LOAD); done_o = (state==DONE); core_rst_o = (state!=DONE).
REQ-030 len_i = 2^LWIDTH-1 loads exactly that many words; counter never wraps within a load.

Reset
REQ-031 rst (synchronous, active-high) forces IDLE regardless of state, including mid-load.
REQ-032 During/after reset: counter 0, latched length 0, checksum_o 0, s_ready_o 0, mem_write_en_o 0, busy_o 0, done_o 0, core_rst_o 1, mem_addr_o BASEADDR.
REQ-033 rst has priority over start_i and handshake in the same cycle; no write is issued in a cycle where rst is high.

Structure
REQ-034 State enum (IDLE/LOAD/DONE) and default BASEADDR constant live in the shared core package used by fetch and memory.
REQ-035 Single flat module; no sub-module required; instantiated in the top level ahead of memory, muxed onto its write port.

Verification
REQ-036 Reset, start_i with len_i=3, words 32'h00000013, 32'h00500093, 32'h00A00113 back-to-back -> writes at 0x01000000/04/08, done_o after 3rd handshake, checksum_o=32'h00F00193 (XOR of the three), core_rst_o falls with done_o.
REQ-037 len_i=4 with s_valid_i toggling 1,0,0,1,1,0,1 -> exactly 4 writes at consecutive addresses, no write during stall cycles, s_ready_o stays 1.
REQ-038 start_i with len_i=0 -> DONE next cycle, zero writes, checksum_o=0, core_rst_o=0.
REQ-039 rst asserted after 2 of 5 words -> next cycle IDLE, core_rst_o=1, counter 0; fresh start_i len_i=2 writes at 0x01000000 and 0x01000004.
REQ-040 start_i pulsed mid-load (len_i=3, new len_i=7) -> ignored; load ends after 3 words; second start_i in DONE restarts at BASEADDR with checksum_o cleared.
REQ-041 BASEADDR=32'hFFFF_FFF8, len_i=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
